lsu_mem_stage: RTL and testbench

//  MEM-stage load/store unit between the EX/MEM register and the MEM/WB register.

---
 rtl/rv32_pkg.sv | 45 ++++
 rtl/lsu_mem_stage_if.sv | 25 ++
 rtl/lsu_load_extend.sv | 26 ++
 rtl/lsu_mem_stage.sv | 125 ++++++++++++
 tb/tb_lsu_mem_stage.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 load/store definitions: funct3 encodings, LSU state type,
// access-size decode and byte-enable generation.
package rv32_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_RD = 2'd1,
    RESP    = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  // Unlisted funct3 encodings fall back to a full-word access.
  function automatic lsu_size_e size_of(input logic [2:0] funct3);
    lsu_size_e sz;
    case (funct3)
      F3_B, F3_BU: sz = SZ_B;
      F3_H, F3_HU: sz = SZ_H;
      F3_W:        sz = SZ_W;
      default:     sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] be;
    case (size_of(funct3))
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = 4'b0011 << {off[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Data-memory req/gnt/rvalid port between the LSU (master) and the data
// memory or bus fabric (slave).
interface lsu_mem_stage_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH/8-1:0]    be;
    logic [WIDTH-1:0]      wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [WIDTH-1:0]      rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/lsu_load_extend.sv
// Selects the addressed byte/half of a loaded word and sign- or zero-extends
// it according to funct3; anything that is not a byte or half passes through.
module lsu_load_extend
    import rv32_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] ext
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{off, 3'b000} +: 8];
    assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        case (funct3)
            F3_B:    ext = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ext = {24'b0, byte_sel};
            F3_H:    ext = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ext = {16'b0, half_sel};
            default: ext = rdata;
        endcase
    end
endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: issues req/gnt/rvalid data-memory accesses and
// stalls the pipeline while a load is outstanding. Optional misaligned-access
// trap is enabled with `define LSU_MISALIGN_TRAP_EN.
module lsu_mem_stage
    import rv32_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  mem_rd_en_m_i,
    input  logic                  mem_wr_en_m_i,
    input  logic [2:0]            funct3_m_i,
    input  logic [ADDR_WIDTH-1:0] addr_m_i,
    input  logic [WIDTH-1:0]      wr_data_m_i,
    output logic [WIDTH-1:0]      read_data_m_o,
    output logic                  stall_m_o,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic                  misalign_o,
`endif
    lsu_mem_stage_if.master       dmem
);
    lsu_state_e      state_q, state_d;
    logic [WIDTH-1:0] rdata_q;
    logic [1:0]      off_q;
    logic [2:0]      f3_q;

    logic            op;
    logic            is_load;
    logic            misalign;
    logic            req;
    logic            stall;
    lsu_size_e       sz;
    logic [WIDTH-1:0] lanes;
    logic [WIDTH-1:0] ext;

    assign is_load = mem_rd_en_m_i;
    assign op      = mem_rd_en_m_i | mem_wr_en_m_i;
    assign sz      = size_of(funct3_m_i);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = op && (state_q == IDLE) &&
                      (((sz == SZ_H) && addr_m_i[0]) ||
                       ((sz == SZ_W) && (addr_m_i[1:0] != 2'b00)));
    assign misalign_o = misalign;
`else
    assign misalign = 1'b0;
`endif

    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (op && !misalign) begin
                    req = 1'b1;
                    if (dmem.gnt) begin
                        if (is_load) begin
                            state_d = WAIT_RD;
                            stall   = 1'b1;
                        end
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
            WAIT_RD: begin
                stall = 1'b1;
                if (dmem.rvalid) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            rdata_q <= '0;
            off_q   <= '0;
            f3_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req && dmem.gnt && is_load) begin
                off_q <= addr_m_i[1:0];
                f3_q  <= funct3_m_i;
            end
            if (state_q == WAIT_RD && dmem.rvalid) rdata_q <= dmem.rdata;
        end
    end

    always_comb begin
        case (sz)
            SZ_B:    lanes = {4{wr_data_m_i[7:0]}};
            SZ_H:    lanes = {2{wr_data_m_i[15:0]}};
            default: lanes = wr_data_m_i;
        endcase
    end

    lsu_load_extend u_load_extend (
        .rdata  (rdata_q),
        .off    (off_q),
        .funct3 (f3_q),
        .ext    (ext)
    );

    // Bus fields are held at zero whenever no request is presented.
    assign dmem.req   = req;
    assign dmem.we    = req & ~is_load;
    assign dmem.addr  = req ? {addr_m_i[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign dmem.be    = req ? be_gen(funct3_m_i, addr_m_i[1:0]) : '0;
    assign dmem.wdata = (req && !is_load) ? lanes : '0;

    assign stall_m_o     = stall;
    assign read_data_m_o = (state_q == RESP) ? ext : '0;

    a_no_dual_op : assert property (@(posedge clk_i) disable iff (!rst_n_i)
                                    !(mem_rd_en_m_i && mem_wr_en_m_i));
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: directed cases plus random loads/stores
// against a behavioural memory-access model.
module tb_lsu_mem_stage;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_en, wr_en;
    logic [2:0]  funct3;
    logic [31:0] addr, wr_data;
    logic [31:0] read_data;
    logic        stall;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int n_cmp = 0;
    int n_err = 0;
    bus_t        req_q[$];
    logic [31:0] rsp_q[$];

    lsu_mem_stage_if #(.WIDTH(32), .ADDR_WIDTH(32)) bus ();

    lsu_mem_stage #(.WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .mem_rd_en_m_i (rd_en),
        .mem_wr_en_m_i (wr_en),
        .funct3_m_i    (funct3),
        .addr_m_i      (addr),
        .wr_data_m_i   (wr_data),
        .read_data_m_o (read_data),
        .stall_m_o     (stall),
`ifdef LSU_MISALIGN_TRAP_EN
        .misalign_o    (misalign),
`endif
        .dmem          (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_bytes(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic bit model_misalign(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        return (a % size_bytes(f3)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bus_t model_bus(input bit ld, input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] d);
        bus_t b;
        int   n;
        n       = size_bytes(f3);
        b.we    = !ld;
        b.addr  = a - (a % 4);
        if (n == 1)      b.be = 4'(1 << (a % 4));
        else if (n == 2) b.be = 4'(3 << ((a % 4) / 2 * 2));
        else             b.be = 4'hF;
        if (ld)          b.wdata = 32'h0;
        else if (n == 1) b.wdata = (d & 32'hFF) * 32'h0101_0101;
        else if (n == 2) b.wdata = (d & 32'hFFFF) * 32'h0001_0001;
        else             b.wdata = d;
        return b;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        logic [31:0] v;
        int          n;
        n = size_bytes(f3);
        if (n == 1) begin
            v = (rd >> ((a % 4) * 8)) & 32'hFF;
            if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
        end else if (n == 2) begin
            v = (rd >> ((a % 4) / 2 * 16)) & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // ---------------- monitor ----------------
    initial begin : monitor
        bus_t  got;
        bit    exp_mis;
        forever begin
            @(negedge clk);
            exp_mis = (rd_en || wr_en) && model_misalign(funct3, addr);
            if (bus.req) begin
                if (req_q.size() == 0) begin
                    check("unexpected_req", 32'(bus.req), 32'h0);
                end else begin
                    got = '{we: bus.we, addr: bus.addr, be: bus.be, wdata: bus.wdata};
                    check("bus_we",    32'(got.we),    32'(req_q[0].we));
                    check("bus_addr",  got.addr,       req_q[0].addr);
                    check("bus_be",    32'(got.be),    32'(req_q[0].be));
                    check("bus_wdata", got.wdata,      req_q[0].wdata);
                    if (bus.gnt) void'(req_q.pop_front());
                end
            end
            if (rd_en && !stall && !exp_mis) begin
                if (rsp_q.size() == 0) check("unexpected_resp", 32'h1, 32'h0);
                else                   check("load_data", read_data, rsp_q.pop_front());
            end else begin
                check("read_data_idle", read_data, 32'h0);
            end
            if (!rd_en && !wr_en) check("stall_idle", 32'(stall), 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
            check("misalign", 32'(misalign), 32'(exp_mis));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_idle();
        rd_en = 1'b0; wr_en = 1'b0;
        bus.gnt = 1'b0; bus.rvalid = 1'b0;
    endtask

    // One access with gnt after gd cycles and (for loads) rvalid rdl cycles after gnt.
    task automatic access(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input int gd, input int rdl,
                          input logic [31:0] rd);
        bit mis;
        bit done;
        int c, stalls, exp_stalls;
        mis = model_misalign(f3, a);
        if (!mis) begin
            req_q.push_back(model_bus(ld, f3, a, d));
            if (ld) rsp_q.push_back(model_load(f3, a, rd));
        end
        exp_stalls = mis ? 0 : (ld ? gd + rdl + 1 : gd);
        @(posedge clk); #1;
        rd_en = ld; wr_en = !ld; funct3 = f3; addr = a; wr_data = d;
        bus.gnt = !mis && (gd == 0); bus.rvalid = 1'b0; bus.rdata = $urandom;
        c = 0; stalls = 0; done = 1'b0;
        while (!done && c < 64) begin
            @(negedge clk);
            if (stall) stalls++; else done = 1'b1;
            @(posedge clk); #1;
            c++;
            if (!done) begin
                bus.gnt    = !mis && (c == gd);
                bus.rvalid = ld && !mis && (c == gd + rdl);
                bus.rdata  = bus.rvalid ? rd : $urandom;
            end
        end
        set_idle();
        check("access_completed", 32'(done), 32'h1);
        check("stall_cycles", stalls, exp_stalls);
    endtask

    task automatic reset_mid_load();
        req_q.push_back(model_bus(1'b1, 3'd0, 32'h102, 32'h0));
        @(posedge clk); #1;
        rd_en = 1'b1; funct3 = 3'd0; addr = 32'h102; bus.gnt = 1'b1;
        @(posedge clk); #1;
        bus.gnt = 1'b0; rd_en = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_req", 32'(bus.req), 32'h0);
        check("rst_read_data", read_data, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.rvalid = 1'b1; bus.rdata = 32'h12F4_5678;
        @(negedge clk);
        check("late_rvalid_stall", 32'(stall), 32'h0);
        @(posedge clk); #1;
        bus.rvalid = 1'b0;
        @(negedge clk);
        check("late_rvalid_read_data", read_data, 32'h0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [2:0] ld_f3 [7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
        bit         ld;
        rst_n = 1'b0; wr_data = '0; funct3 = '0; addr = '0;
        bus.rdata = '0;
        set_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_req", 32'(bus.req), 32'h0);
        check("reset_stall", 32'(stall), 32'h0);
        check("reset_read_data", read_data, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        access(1'b0, 3'd2, 32'h100, 32'hDEADBEEF, 0, 1, 32'h0);
        access(1'b0, 3'd0, 32'h103, 32'h0000_00A5, 2, 1, 32'h0);
        access(1'b1, 3'd0, 32'h102, 32'h0, 0, 3, 32'h12F4_5678);
        access(1'b1, 3'd4, 32'h102, 32'h0, 0, 3, 32'h12F4_5678);
        access(1'b1, 3'd1, 32'h102, 32'h0, 1, 1, 32'h8001_7FFF);
        access(1'b1, 3'd5, 32'h102, 32'h0, 0, 2, 32'h8001_7FFF);
        access(1'b1, 3'd2, 32'h100, 32'h0, 0, 1, 32'h8001_7FFF);
        reset_mid_load();
        access(1'b1, 3'd2, 32'h101, 32'h0, 0, 1, 32'hCAFE_F00D);
        access(1'b1, 3'd1, 32'h203, 32'h0, 1, 2, 32'h8765_4321);
        access(1'b0, 3'd1, 32'h301, 32'h0000_BEEF, 0, 1, 32'h0);

        for (int i = 0; i < 60; i++) begin
            ld = $urandom_range(0, 1);
            access(ld, ld ? ld_f3[$urandom_range(0, 6)] : 3'($urandom_range(0, 2)),
                   $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 4), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                bus.rvalid = 1'b1; bus.rdata = $urandom;
                @(posedge clk); #1;
                bus.rvalid = 1'b0;
            end
        end

        repeat (3) @(posedge clk);
        check("req_queue_drained", req_q.size(), 32'h0);
        check("rsp_queue_drained", rsp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
